jtcontra_muldiv: RTL and testbench

Parametrised successor to the Konami 007452 arithmetic helper used by the Contra-family CPU maps. Holds a sequential shift-add multiplier and a restoring divider, each with its own start trigger, busy flag and result registers. Adds configurable widths, optional signed mode, divide-by-zero flagging, and results that stay stable until a computation completes. Sits on the main CPU bus behind a chip select, 8-bit data, read mux combinational.

---
 rtl/jtcontra_muldiv_pkg.sv | 52 +++++
 rtl/jtcontra_muldiv_div.sv | 141 ++++++++++++++
 rtl/jtcontra_muldiv.sv | 224 ++++++++++++++++++++++
 tb/tb_jtcontra_muldiv.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtcontra_muldiv_pkg.sv
// jtcontra_muldiv_pkg
// Shared definitions for the jtcontra_muldiv arithmetic helper:
//   - write/read register indices on the 4-bit CPU address
//   - engine state encoding shared by the multiplier and divider FSMs
//   - status byte bit positions
//   - put_byte: replace one byte of a 16-bit operand image
package jtcontra_muldiv_pkg;

   // Write map
   localparam logic [3:0] W_A_HI   = 4'd0;
   localparam logic [3:0] W_A_LO   = 4'd1;
   localparam logic [3:0] W_B_HI   = 4'd2;
   localparam logic [3:0] W_B_LO   = 4'd3;  // also starts the multiplier
   localparam logic [3:0] W_DVS_HI = 4'd4;
   localparam logic [3:0] W_DVS_LO = 4'd5;
   localparam logic [3:0] W_DVD_HI = 4'd6;
   localparam logic [3:0] W_DVD_LO = 4'd7;  // also starts the divider
   localparam logic [3:0] W_CTRL   = 4'd8;

   // Read map
   localparam logic [3:0] R_P0     = 4'd0;
   localparam logic [3:0] R_P1     = 4'd1;
   localparam logic [3:0] R_P2     = 4'd2;
   localparam logic [3:0] R_P3     = 4'd3;
   localparam logic [3:0] R_REM_LO = 4'd4;
   localparam logic [3:0] R_REM_HI = 4'd5;
   localparam logic [3:0] R_QUO_LO = 4'd6;
   localparam logic [3:0] R_QUO_HI = 4'd7;
   localparam logic [3:0] R_STATUS = 4'd8;

   // Status byte layout: {3'b0, ctrl[1:0], dz, div_busy, mul_busy}
   localparam int SB_MUL_BUSY = 0;
   localparam int SB_DIV_BUSY = 1;
   localparam int SB_DZ       = 2;
   localparam int SB_CTRL     = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_FIX
   } eng_st_e;

   // Operands are written a byte at a time into a 16-bit image; the caller
   // truncates to the configured width, which discards the unused upper bits.
   function automatic logic [15:0] put_byte(input logic [15:0] cur,
                                            input logic        hi,
                                            input logic [7:0]  b);
      return hi ? {b, cur[7:0]} : {cur[15:8], b};
   endfunction

endpackage

// File: rtl/jtcontra_muldiv_div.sv
// jtcontra_muldiv_div
// Iterative restoring divider engine, one quotient bit per clock.
// FSM IDLE -> LOAD -> RUN (DW cycles) -> FIX -> IDLE; a start in any state
// aborts and reloads. Results only change in FIX.
// Optional signed mode under `JTCONTRA_MULDIV_SIGNED_EN (adds sgn_i).
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start_i      start pulse (dividend-low write)
//   sgn_i        signed divide select, sampled in LOAD (macro builds only)
//   dvd_i/dvs_i  dividend / divisor operand registers
//   busy_o       high from LOAD through FIX
//   dz_o         last completed divide had a zero divisor
//   quo_o/rem_o  result registers
module jtcontra_muldiv_div
   import jtcontra_muldiv_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_i,
`ifdef JTCONTRA_MULDIV_SIGNED_EN
   input  logic          sgn_i,
`endif
   input  logic [DW-1:0] dvd_i,
   input  logic [DW-1:0] dvs_i,
   output logic          busy_o,
   output logic          dz_o,
   output logic [DW-1:0] quo_o,
   output logic [DW-1:0] rem_o
);
   localparam int CW = $clog2(DW + 1);

   eng_st_e       st_q;
   logic [DW-1:0] wdvs_q;   // divisor magnitude
   logic [DW-1:0] wquo_q;   // dividend bits shift out, quotient bits shift in
   logic [DW-1:0] wrem_q;   // partial remainder
   logic [DW-1:0] raw_q;    // dividend as written, returned on divide-by-zero
   logic [CW-1:0] cnt_q;
   logic          zero_q;
`ifdef JTCONTRA_MULDIV_SIGNED_EN
   logic          qneg_q;
   logic          rneg_q;
   logic          q_neg;
   logic          r_neg;
`endif

   logic [DW-1:0] dvd_mag;
   logic [DW-1:0] dvs_mag;
   logic [DW:0]   rem_sh;
   logic          fit;
   logic [DW-1:0] rem_nx;
   logic [DW-1:0] quo_nx;

   always_comb begin
      dvd_mag = dvd_i;
      dvs_mag = dvs_i;
`ifdef JTCONTRA_MULDIV_SIGNED_EN
      q_neg = 1'b0;
      r_neg = 1'b0;
      if (sgn_i) begin
         if (dvd_i[DW-1]) dvd_mag = -dvd_i;
         if (dvs_i[DW-1]) dvs_mag = -dvs_i;
         q_neg = dvd_i[DW-1] ^ dvs_i[DW-1];
         r_neg = dvd_i[DW-1];   // remainder follows the dividend
      end
`endif
      // Shift the next dividend bit into the remainder and try the subtract.
      rem_sh = {wrem_q, wquo_q[DW-1]};
      fit    = (rem_sh >= {1'b0, wdvs_q});
      rem_nx = fit ? DW'(rem_sh - {1'b0, wdvs_q}) : rem_sh[DW-1:0];
      quo_nx = DW'({wquo_q, fit});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= ST_IDLE;
         busy_o <= 1'b0;
         dz_o   <= 1'b0;
         quo_o  <= '0;
         rem_o  <= '0;
         wdvs_q <= '0;
         wquo_q <= '0;
         wrem_q <= '0;
         raw_q  <= '0;
         cnt_q  <= '0;
         zero_q <= 1'b0;
`ifdef JTCONTRA_MULDIV_SIGNED_EN
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
`endif
      end else if (start_i) begin
         // Restart has priority over every state, including FIX.
         st_q   <= ST_LOAD;
         busy_o <= 1'b1;
         dz_o   <= 1'b0;
      end else begin
         case (st_q)
            ST_LOAD: begin
               wdvs_q <= dvs_mag;
               wquo_q <= dvd_mag;
               wrem_q <= '0;
               raw_q  <= dvd_i;
               zero_q <= (dvs_i == '0);
               cnt_q  <= '0;
`ifdef JTCONTRA_MULDIV_SIGNED_EN
               qneg_q <= q_neg;
               rneg_q <= r_neg;
`endif
               st_q   <= ST_RUN;
            end
            ST_RUN: begin
               wquo_q <= quo_nx;
               wrem_q <= rem_nx;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == CW'(DW - 1)) st_q <= ST_FIX;
            end
            ST_FIX: begin
               if (zero_q) begin
                  // Zero divisor: fixed pattern, no sign correction.
                  quo_o <= '1;
                  rem_o <= raw_q;
                  dz_o  <= 1'b1;
               end else begin
`ifdef JTCONTRA_MULDIV_SIGNED_EN
                  quo_o <= qneg_q ? -wquo_q : wquo_q;
                  rem_o <= rneg_q ? -wrem_q : wrem_q;
`else
                  quo_o <= wquo_q;
                  rem_o <= wrem_q;
`endif
               end
               busy_o <= 1'b0;
               st_q   <= ST_IDLE;
            end
            default: st_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/jtcontra_muldiv.sv
// jtcontra_muldiv
// CPU-mapped arithmetic helper: shift-add multiplier (inline) and restoring
// divider (jtcontra_muldiv_div), independent, each with its own start, busy
// and result registers. Results are held until the engine's FIX state.
// Define JTCONTRA_MULDIV_SIGNED_EN to enable signed mode through ctrl[1:0];
// otherwise both engines are unsigned and ctrl reads 0.
// Ports:
//   clk    system clock (rising edge)
//   rst_n  async active-low reset
//   cs     chip select
//   wrn    active-low write strobe; write on each edge with cs && !wrn
//   addr   register index
//   din    write data
//   dout   read data, combinational from addr
module jtcontra_muldiv
   import jtcontra_muldiv_pkg::*;
#(
   parameter int MW = 8,
   parameter int DW = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cs,
   input  logic       wrn,
   input  logic [3:0] addr,
   input  logic [7:0] din,
   output logic [7:0] dout
);
   localparam int PW  = 2 * MW;
   localparam int MCW = $clog2(MW + 1);

   logic          wr;
   logic          mstart;
   logic          dstart;

   // Operand registers, rewritable at any time
   logic [MW-1:0] a_q;
   logic [MW-1:0] b_q;
   logic [DW-1:0] dvs_q;
   logic [DW-1:0] dvd_q;
   logic [1:0]    ctrl_rd;
`ifdef JTCONTRA_MULDIV_SIGNED_EN
   logic [1:0]    ctrl_q;
`endif

   // Multiplier engine
   eng_st_e        mst_q;
   logic           mbusy_q;
   logic [MW-1:0]  ma_q;     // multiplicand magnitude
   logic [PW-1:0]  mp_q;     // {accumulator, multiplier}
   logic [MCW-1:0] mcnt_q;
   logic [PW-1:0]  prod_q;
`ifdef JTCONTRA_MULDIV_SIGNED_EN
   logic           mneg_q;
   logic           m_neg;
`endif
   logic [MW-1:0]  a_mag;
   logic [MW-1:0]  b_mag;
   logic [MW:0]    m_sum;
   logic [PW-1:0]  m_nxt;

   // Divider outputs
   logic          dbusy;
   logic          dz;
   logic [DW-1:0] quo;
   logic [DW-1:0] rem;

   logic [31:0]   p32;
   logic [15:0]   quo16;
   logic [15:0]   rem16;
   logic [7:0]    status;

   assign wr     = cs && !wrn;
   assign mstart = wr && (addr == W_B_LO);
   assign dstart = wr && (addr == W_DVD_LO);

   // ---------------------------------------------------------------- writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         dvs_q  <= '0;
         dvd_q  <= '0;
`ifdef JTCONTRA_MULDIV_SIGNED_EN
         ctrl_q <= 2'b00;
`endif
      end else if (wr) begin
         case (addr)
            W_A_HI, W_A_LO:
               a_q <= MW'(put_byte(16'(a_q), addr == W_A_HI, din));
            W_B_HI, W_B_LO:
               b_q <= MW'(put_byte(16'(b_q), addr == W_B_HI, din));
            W_DVS_HI, W_DVS_LO:
               dvs_q <= DW'(put_byte(16'(dvs_q), addr == W_DVS_HI, din));
            W_DVD_HI, W_DVD_LO:
               dvd_q <= DW'(put_byte(16'(dvd_q), addr == W_DVD_HI, din));
            W_CTRL: begin
`ifdef JTCONTRA_MULDIV_SIGNED_EN
               ctrl_q <= din[1:0];
`endif
            end
            default: ;
         endcase
      end
   end

`ifdef JTCONTRA_MULDIV_SIGNED_EN
   assign ctrl_rd = ctrl_q;
`else
   assign ctrl_rd = 2'b00;
`endif

   // ------------------------------------------------------------ multiplier
   always_comb begin
      a_mag = a_q;
      b_mag = b_q;
`ifdef JTCONTRA_MULDIV_SIGNED_EN
      m_neg = 1'b0;
      if (ctrl_q[0]) begin
         if (a_q[MW-1]) a_mag = -a_q;
         if (b_q[MW-1]) b_mag = -b_q;
         m_neg = a_q[MW-1] ^ b_q[MW-1];
      end
`endif
      // Add the multiplicand into the upper half when the current multiplier
      // bit is set, then shift the whole {acc, multiplier} pair right.
      m_sum = {1'b0, mp_q[PW-1:MW]} + {1'b0, (mp_q[0] ? ma_q : {MW{1'b0}})};
      m_nxt = PW'({m_sum, mp_q[MW-1:0]} >> 1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mst_q   <= ST_IDLE;
         mbusy_q <= 1'b0;
         ma_q    <= '0;
         mp_q    <= '0;
         mcnt_q  <= '0;
         prod_q  <= '0;
`ifdef JTCONTRA_MULDIV_SIGNED_EN
         mneg_q  <= 1'b0;
`endif
      end else if (mstart) begin
         // Restart has priority over every state, including FIX.
         mst_q   <= ST_LOAD;
         mbusy_q <= 1'b1;
      end else begin
         case (mst_q)
            ST_LOAD: begin
               ma_q   <= a_mag;
               mp_q   <= {{MW{1'b0}}, b_mag};
               mcnt_q <= '0;
`ifdef JTCONTRA_MULDIV_SIGNED_EN
               mneg_q <= m_neg;
`endif
               mst_q  <= ST_RUN;
            end
            ST_RUN: begin
               mp_q   <= m_nxt;
               mcnt_q <= mcnt_q + 1'b1;
               if (mcnt_q == MCW'(MW - 1)) mst_q <= ST_FIX;
            end
            ST_FIX: begin
`ifdef JTCONTRA_MULDIV_SIGNED_EN
               prod_q <= mneg_q ? -mp_q : mp_q;
`else
               prod_q <= mp_q;
`endif
               mbusy_q <= 1'b0;
               mst_q   <= ST_IDLE;
            end
            default: mst_q <= ST_IDLE;
         endcase
      end
   end

   // --------------------------------------------------------------- divider
   jtcontra_muldiv_div #(
      .DW(DW)
   ) u_div (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (dstart),
`ifdef JTCONTRA_MULDIV_SIGNED_EN
      .sgn_i   (ctrl_q[1]),
`endif
      .dvd_i   (dvd_q),
      .dvs_i   (dvs_q),
      .busy_o  (dbusy),
      .dz_o    (dz),
      .quo_o   (quo),
      .rem_o   (rem)
   );

   // ------------------------------------------------------------- read mux
   // Results are zero-extended so bytes above the configured width read 0.
   assign p32   = 32'(prod_q);
   assign quo16 = 16'(quo);
   assign rem16 = 16'(rem);

   always_comb begin
      status                   = 8'h00;
      status[SB_MUL_BUSY]      = mbusy_q;
      status[SB_DIV_BUSY]      = dbusy;
      status[SB_DZ]            = dz;
      status[SB_CTRL +: 2]     = ctrl_rd;
   end

   always_comb begin
      dout = 8'h00;
      case (addr)
         R_P0:     dout = p32[7:0];
         R_P1:     dout = p32[15:8];
         R_P2:     dout = p32[23:16];
         R_P3:     dout = p32[31:24];
         R_REM_LO: dout = rem16[7:0];
         R_REM_HI: dout = rem16[15:8];
         R_QUO_LO: dout = quo16[7:0];
         R_QUO_HI: dout = quo16[15:8];
         R_STATUS: dout = status;
         default:  dout = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_jtcontra_muldiv.sv
// tb_jtcontra_muldiv
// Directed bench for jtcontra_muldiv with MW=8, DW=16. Covers reset state,
// multiply/divide latency and results, divide-by-zero, restart while busy,
// reset mid-divide, and signed or unsigned behaviour depending on
// JTCONTRA_MULDIV_SIGNED_EN.
module tb_jtcontra_muldiv;
   localparam int MW = 8;
   localparam int DW = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cs;
   logic       wrn;
   logic [3:0] addr;
   logic [7:0] din;
   logic [7:0] dout;

   int n_chk = 0;
   int n_bad = 0;

   jtcontra_muldiv #(.MW(MW), .DW(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .cs    (cs),
      .wrn   (wrn),
      .addr  (addr),
      .din   (din),
      .dout  (dout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Returns 1ns after the write edge.
   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      addr = a;
      din  = d;
      cs   = 1'b1;
      wrn  = 1'b0;
      @(posedge clk);
      #1;
      cs   = 1'b0;
      wrn  = 1'b1;
   endtask

   task automatic rd(input logic [3:0] a, output logic [7:0] d);
      addr = a;
      #1;
      d = dout;
   endtask

   task automatic rd16(input logic [3:0] a, output logic [15:0] d);
      logic [7:0] lo, hi;
      rd(a, lo);
      rd(4'(a + 4'd1), hi);
      d = {hi, lo};
   endtask

   task automatic chk_div(input string tag, input logic [15:0] q, input logic [15:0] r);
      logic [15:0] v;
      rd16(4'd6, v);
      chk({tag, "_quo"}, 32'(v), 32'(q));
      rd16(4'd4, v);
      chk({tag, "_rem"}, 32'(v), 32'(r));
   endtask

   task automatic chk_prod(input string tag, input logic [31:0] p);
      logic [15:0] lo, hi;
      rd16(4'd0, lo);
      rd16(4'd2, hi);
      chk({tag, "_prod"}, {hi, lo}, p);
   endtask

   task automatic chk_stat(input string tag, input logic [7:0] s);
      logic [7:0] v;
      rd(4'd8, v);
      chk({tag, "_stat"}, 32'(v), 32'(s));
   endtask

   task automatic do_div(input logic [15:0] dvd, input logic [15:0] dvs);
      wr(4'd4, dvs[15:8]);
      wr(4'd5, dvs[7:0]);
      wr(4'd6, dvd[15:8]);
      wr(4'd7, dvd[7:0]);
   endtask

   task automatic do_mul(input logic [7:0] a, input logic [7:0] b);
      wr(4'd0, 8'h00);
      wr(4'd1, a);
      wr(4'd2, 8'h00);
      wr(4'd3, b);
   endtask

   initial begin
      logic [7:0] v8;
      rst_n = 1'b0;
      cs    = 1'b0;
      wrn   = 1'b1;
      addr  = 4'd0;
      din   = 8'h00;
      step(2);

      // Reset state: every address reads 0
      for (int a = 0; a < 9; a++) begin
         rd(4'(a), v8);
         chk($sformatf("rst_addr%0d", a), 32'(v8), 32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(1);

      // Unsigned multiply 0x7F * 0xFF = 0x7E81, MW+2 = 10 cycle latency
      do_mul(8'h7F, 8'hFF);
      chk_stat("mul_k0", 8'h01);
      step(1);
      chk_stat("mul_k1", 8'h01);
      step(8);
      chk_stat("mul_k9", 8'h01);
      chk_prod("mul_k9", 32'h0);
      step(1);
      chk_stat("mul_k10", 8'h00);
      chk_prod("mul_k10", 32'h0000_7E81);

      // Unsigned divide 1000 / 7 = 142 r 6, DW+2 = 18 cycles
      do_div(16'd1000, 16'd7);
      step(17);
      chk_stat("div_k17", 8'h02);
      chk_div("div_k17", 16'h0000, 16'h0000);
      step(1);
      chk_stat("div_k18", 8'h00);
      chk_div("div_k18", 16'h008E, 16'h0006);

      // Divide by zero
      do_div(16'h1234, 16'h0000);
      step(18);
      chk_div("dz", 16'hFFFF, 16'h1234);
      chk_stat("dz", 8'h04);
      // Next start clears dz immediately
      do_div(16'd100, 16'd10);
      chk_stat("dz_clr", 8'h02);
      step(18);
      chk_div("div100", 16'h000A, 16'h0000);
      chk_stat("div100", 8'h00);

      // Restart while busy: 1000/7 then 50/7 at cycle 5
      do_div(16'd1000, 16'd7);
      chk_stat("rs_k0", 8'h02);
      wr(4'd6, 8'h00);          // k=1, dividend high staged for 50
      step(3);                  // k=4
      chk_div("rs_k4", 16'h000A, 16'h0000);
      wr(4'd7, 8'd50);          // k=5, second start
      chk_stat("rs_w0", 8'h02);
      step(13);                 // first divide would have finished here
      chk_stat("rs_w13", 8'h02);
      chk_div("rs_w13", 16'h000A, 16'h0000);
      step(4);
      chk_stat("rs_w17", 8'h02);
      step(1);
      chk_stat("rs_w18", 8'h00);
      chk_div("rs_w18", 16'h0007, 16'h0001);

      // Reset mid-divide
      do_div(16'd1000, 16'd7);
      step(8);
      rst_n = 1'b0;
      #1;
      for (int a = 0; a < 16; a++) begin
         rd(4'(a), v8);
         chk($sformatf("mrst_addr%0d", a), 32'(v8), 32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(1);
      chk_stat("mrst_rel", 8'h00);
      do_div(16'd200, 16'd9);
      step(18);
      chk_div("mrst_div", 16'h0016, 16'h0002);
      chk_stat("mrst_div", 8'h00);

`ifdef JTCONTRA_MULDIV_SIGNED_EN
      wr(4'd8, 8'h03);
      chk_stat("sg_ctrl", 8'h18);
      do_div(16'hFFF9, 16'h0002);             // -7 / 2
      step(18);
      chk_div("sg_m7d2", 16'hFFFD, 16'hFFFF);
      chk_stat("sg_m7d2", 8'h18);
      do_div(16'h0007, 16'hFFFE);             // 7 / -2
      step(18);
      chk_div("sg_7dm2", 16'hFFFD, 16'h0001);
      do_div(16'h8000, 16'hFFFF);             // most negative / -1
      step(18);
      chk_div("sg_ovf", 16'h8000, 16'h0000);
      do_mul(8'hFD, 8'h05);                   // -3 * 5
      step(10);
      chk_prod("sg_m3x5", 32'h0000_FFF1);
      do_mul(8'h80, 8'h80);                   // -128 * -128
      step(10);
      chk_prod("sg_m128sq", 32'h0000_4000);
`else
      wr(4'd8, 8'h03);
      chk_stat("us_ctrl", 8'h00);
      do_div(16'hFFF9, 16'h0002);
      step(18);
      chk_div("us_div", 16'h7FFC, 16'h0001);
      do_mul(8'hFD, 8'h05);
      step(10);
      chk_prod("us_mul", 32'h0000_04F1);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
